// File: rtl/nv_nvdla_pdp_rdma_reg_single_mg.sv
// nv_nvdla_pdp_rdma_reg_single_mg
// Single-register block for the PDP RDMA register file. It holds an N-group
// producer pointer (loadable or auto-advancing), reads back the per-group
// status and the consumer pointer, and optionally keeps a sticky per-group
// done interrupt with a mask and write-1-to-clear.
//
// Optional feature macro: NVDLA_PDP_RDMA_INTR_EN
//   defined   -> S_INTR_STATUS / S_INTR_MASK / intr are built
//   undefined -> 0x008 / 0x00C behave as unmapped, intr tied 0
//
// Ports:
//   nvdla_core_clk  core clock
//   nvdla_core_rst  synchronous active-high reset
//   reg_offset      register byte offset
//   reg_wr_data     write data
//   reg_wr_en       single-cycle write strobe
//   reg_rd_data     combinational read data for reg_offset
//   producer        group being programmed by the CSB side
//   consumer        group being executed by the datapath
//   status          per-group status, group g at [g*STATUS_W +: STATUS_W]
//   done_pulse      one-cycle completion pulse per group
//   intr            registered interrupt request
module nv_nvdla_pdp_rdma_reg_single_mg #(
  parameter int unsigned NUM_GROUPS = 2,
  parameter int unsigned STATUS_W   = 2,
  localparam int unsigned PTR_W     = $clog2(NUM_GROUPS)
) (
  input  logic                           nvdla_core_clk,
  input  logic                           nvdla_core_rst,
  input  logic [11:0]                    reg_offset,
  input  logic [31:0]                    reg_wr_data,
  input  logic                           reg_wr_en,
  output logic [31:0]                    reg_rd_data,
  output logic [PTR_W-1:0]               producer,
  input  logic [PTR_W-1:0]               consumer,
  input  logic [NUM_GROUPS*STATUS_W-1:0] status,
  input  logic [NUM_GROUPS-1:0]          done_pulse,
  output logic                           intr
);

  localparam logic [11:0] OFF_STATUS      = 12'h000;
  localparam logic [11:0] OFF_POINTER     = 12'h004;
  localparam logic [11:0] OFF_INTR_STATUS = 12'h008;
  localparam logic [11:0] OFF_INTR_MASK   = 12'h00C;

  logic [PTR_W-1:0] producer_q;
  logic [PTR_W-1:0] producer_d;

  // Bits of the write bus that no field decodes, plus done_pulse when the
  // interrupt logic is compiled out.
  logic unused_c;
  assign unused_c = ^{reg_wr_data, done_pulse};

  // Pointer next state: ADVANCE (bit 31) steps with natural power-of-two wrap.
  always_comb begin
    producer_d = producer_q;
    if (reg_wr_en && (reg_offset == OFF_POINTER)) begin
      if (reg_wr_data[31]) begin
        producer_d = PTR_W'(producer_q + 1'b1);
      end else begin
        producer_d = reg_wr_data[PTR_W-1:0];
      end
    end
  end

  // Pointer state register.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      producer_q <= '0;
    end else begin
      producer_q <= producer_d;
    end
  end

  assign producer = producer_q;

`ifdef NVDLA_PDP_RDMA_INTR_EN
  logic [NUM_GROUPS-1:0] intr_status_q;
  logic [NUM_GROUPS-1:0] intr_status_d;
  logic [NUM_GROUPS-1:0] intr_mask_q;
  logic [NUM_GROUPS-1:0] intr_mask_d;
  logic                  intr_q;
  logic                  intr_d;

  // Sticky status: a done pulse overrides a same-cycle W1C of that bit.
  always_comb begin
    intr_status_d = intr_status_q;
    intr_mask_d   = intr_mask_q;
    if (reg_wr_en && (reg_offset == OFF_INTR_STATUS)) begin
      intr_status_d = intr_status_q & ~reg_wr_data[NUM_GROUPS-1:0];
    end
    intr_status_d = intr_status_d | done_pulse;
    if (reg_wr_en && (reg_offset == OFF_INTR_MASK)) begin
      intr_mask_d = reg_wr_data[NUM_GROUPS-1:0];
    end
    // One flop after the status/mask registers.
    intr_d = |(intr_status_q & ~intr_mask_q);
  end

  // Interrupt state registers; everything masked out of reset.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      intr_status_q <= '0;
      intr_mask_q   <= '1;
      intr_q        <= 1'b0;
    end else begin
      intr_status_q <= intr_status_d;
      intr_mask_q   <= intr_mask_d;
      intr_q        <= intr_d;
    end
  end

  assign intr = intr_q;
`else
  assign intr = 1'b0;
`endif

  // Read mux: purely a function of reg_offset and current state.
  always_comb begin
    reg_rd_data = '0;
    case (reg_offset)
      OFF_STATUS: begin
        for (int g = 0; g < int'(NUM_GROUPS); g++) begin
          reg_rd_data[4*g +: STATUS_W] = status[g*STATUS_W +: STATUS_W];
        end
      end
      OFF_POINTER: begin
        reg_rd_data[PTR_W-1:0]  = producer_q;
        reg_rd_data[16 +: PTR_W] = consumer;
      end
`ifdef NVDLA_PDP_RDMA_INTR_EN
      OFF_INTR_STATUS: reg_rd_data[NUM_GROUPS-1:0] = intr_status_q;
      OFF_INTR_MASK:   reg_rd_data[NUM_GROUPS-1:0] = intr_mask_q;
`endif
      default: reg_rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_nv_nvdla_pdp_rdma_reg_single_mg.sv
// Directed bench for nv_nvdla_pdp_rdma_reg_single_mg with NUM_GROUPS=4,
// STATUS_W=2. Interrupt expectations follow NVDLA_PDP_RDMA_INTR_EN.
module tb_nv_nvdla_pdp_rdma_reg_single_mg;

  logic        clk;
  logic        rst;
  logic [11:0] reg_offset;
  logic [31:0] reg_wr_data;
  logic        reg_wr_en;
  logic [31:0] reg_rd_data;
  logic [1:0]  producer;
  logic [1:0]  consumer;
  logic [7:0]  status;
  logic [3:0]  done_pulse;
  logic        intr;

  int n_cmp = 0;
  int n_err = 0;

  nv_nvdla_pdp_rdma_reg_single_mg #(.NUM_GROUPS(4), .STATUS_W(2)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .reg_offset     (reg_offset),
    .reg_wr_data    (reg_wr_data),
    .reg_wr_en      (reg_wr_en),
    .reg_rd_data    (reg_rd_data),
    .producer       (producer),
    .consumer       (consumer),
    .status         (status),
    .done_pulse     (done_pulse),
    .intr           (intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // One clock edge with the given write/pulse inputs, then release strobes.
  task automatic step(input logic we, input logic [11:0] off, input logic [31:0] d,
                      input logic [3:0] dp);
    reg_wr_en   = we;
    reg_offset  = off;
    reg_wr_data = d;
    done_pulse  = dp;
    @(posedge clk);
    #1;
    reg_wr_en  = 1'b0;
    done_pulse = 4'h0;
  endtask

  task automatic rd(input string tag, input logic [11:0] off, input logic [31:0] exp);
    reg_offset = off;
    #1;
    chk(tag, reg_rd_data, exp);
  endtask

  task automatic chk_intr(input string tag, input logic exp);
    chk(tag, {31'b0, intr}, {31'b0, exp});
  endtask

  initial begin
    rst         = 1'b1;
    reg_offset  = '0;
    reg_wr_data = '0;
    reg_wr_en   = 1'b0;
    done_pulse  = '0;
    consumer    = 2'd1;
    status      = 8'b11_10_01_00;
    step(1'b0, 12'h000, 32'h0, 4'h0);
    step(1'b0, 12'h000, 32'h0, 4'h0);
    rst = 1'b0;

    // Reset state readback.
    rd("rst_status", 12'h000, 32'h0000_3210);
    rd("rst_ptr",    12'h004, 32'h0001_0000);
    rd("rst_istat",  12'h008, 32'h0);
`ifdef NVDLA_PDP_RDMA_INTR_EN
    rd("rst_mask",   12'h00C, 32'h0000_000F);
`else
    rd("rst_mask",   12'h00C, 32'h0);
`endif
    chk_intr("rst_intr", 1'b0);

    // ADVANCE five times: 1,2,3,0,1; bit 31 always reads 0.
    step(1'b1, 12'h004, 32'h8000_0000, 4'h0);
    rd("adv1", 12'h004, 32'h0001_0001);
    step(1'b1, 12'h004, 32'h8000_0000, 4'h0);
    rd("adv2", 12'h004, 32'h0001_0002);
    step(1'b1, 12'h004, 32'h8000_0003, 4'h0);
    rd("adv3", 12'h004, 32'h0001_0003);
    step(1'b1, 12'h004, 32'h8000_0000, 4'h0);
    rd("adv0_wrap", 12'h004, 32'h0001_0000);
    chk("adv0_port", 32'(producer), 32'd0);
    step(1'b1, 12'h004, 32'h8000_0000, 4'h0);
    rd("adv1_again", 12'h004, 32'h0001_0001);

    // Direct load, consumer/status readback.
    step(1'b1, 12'h004, 32'h0000_0002, 4'h0);
    consumer = 2'd3;
    status   = 8'b00_00_10_00;
    rd("load_ptr",    12'h004, 32'h0003_0002);
    rd("load_status", 12'h000, 32'h0000_0020);
    chk("load_port", 32'(producer), 32'd2);

    // Ignored writes to the RO status register and an unmapped offset.
    step(1'b1, 12'h000, 32'hFFFF_FFFF, 4'h0);
    step(1'b1, 12'h010, 32'h8000_0001, 4'h0);
    rd("ign_status", 12'h000, 32'h0000_0020);
    rd("ign_ptr",    12'h004, 32'h0003_0002);
    rd("ign_unmap",  12'h010, 32'h0);

`ifdef NVDLA_PDP_RDMA_INTR_EN
    // Unmask all, then done_pulse[2].
    step(1'b1, 12'h00C, 32'h0, 4'h0);
    rd("mask_clr", 12'h00C, 32'h0);
    chk_intr("intr_idle", 1'b0);
    step(1'b0, 12'h000, 32'h0, 4'b0100);
    rd("done2_stat", 12'h008, 32'h4);
    chk_intr("done2_intr_N", 1'b0);
    step(1'b0, 12'h000, 32'h0, 4'h0);
    chk_intr("done2_intr_N1", 1'b1);
    step(1'b1, 12'h008, 32'h4, 4'h0);
    rd("w1c_stat", 12'h008, 32'h0);
    chk_intr("w1c_intr_M", 1'b1);
    step(1'b0, 12'h000, 32'h0, 4'h0);
    chk_intr("w1c_intr_M1", 1'b0);

    // Same-cycle set and clear of bit 1: set wins.
    step(1'b0, 12'h000, 32'h0, 4'b0010);
    step(1'b0, 12'h000, 32'h0, 4'h0);
    chk_intr("b1_intr", 1'b1);
    step(1'b1, 12'h008, 32'h2, 4'b0010);
    rd("setwin_stat", 12'h008, 32'h2);
    step(1'b0, 12'h000, 32'h0, 4'h0);
    chk_intr("setwin_intr", 1'b1);
    step(1'b1, 12'h008, 32'hFFFF_FFFF, 4'h0);
    rd("clrall_stat", 12'h008, 32'h0);
    step(1'b0, 12'h000, 32'h0, 4'h0);
    chk_intr("clrall_intr", 1'b0);

    // Mask change reaches intr one edge later.
    step(1'b0, 12'h000, 32'h0, 4'b1000);
    step(1'b0, 12'h000, 32'h0, 4'h0);
    chk_intr("g3_intr", 1'b1);
    step(1'b1, 12'h00C, 32'h8, 4'h0);
    rd("mask8", 12'h00C, 32'h8);
    chk_intr("mask_intr_M", 1'b1);
    step(1'b0, 12'h000, 32'h0, 4'h0);
    chk_intr("mask_intr_M1", 1'b0);
    rd("mask_stat_kept", 12'h008, 32'h8);
`else
    // Interrupt logic absent: offsets unmapped, intr stuck low.
    step(1'b1, 12'h00C, 32'h0, 4'hF);
    step(1'b1, 12'h008, 32'hF, 4'hF);
    step(1'b0, 12'h000, 32'h0, 4'hF);
    rd("noint_stat", 12'h008, 32'h0);
    rd("noint_mask", 12'h00C, 32'h0);
    chk_intr("noint_intr", 1'b0);
    step(1'b0, 12'h000, 32'h0, 4'h0);
    chk_intr("noint_intr2", 1'b0);
`endif

    // Reset with a concurrent write and done pulse: all state cleared.
    rst = 1'b1;
    step(1'b1, 12'h004, 32'h8000_0000, 4'hF);
    rst = 1'b0;
    rd("mrst_ptr",   12'h004, 32'h0003_0000);
    rd("mrst_istat", 12'h008, 32'h0);
`ifdef NVDLA_PDP_RDMA_INTR_EN
    rd("mrst_mask",  12'h00C, 32'h0000_000F);
`else
    rd("mrst_mask",  12'h00C, 32'h0);
`endif
    chk_intr("mrst_intr", 1'b0);
    step(1'b0, 12'h000, 32'h0, 4'h0);
    chk_intr("mrst_intr2", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
